// File: rtl/mem_1w1r_ext.sv
// Single-write/single-read RAM with per-lane write mask, optional write-first
// forwarding, optional output pipeline stage and optional clear-after-reset sweep.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweeping entries 0..ELEMENTS-1 to zero, busy=1, ports ignored
// ST_READY | normal operation, busy=0, left only through rst
module mem_1w1r_ext #(
   parameter int ELEMENTS_W     = 7,
   parameter int WIDTH          = 32,
   parameter int GRAN           = 8,
   parameter int BYPASS         = 1,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ELEMENTS_W-1:0]       readaddress,
   input  logic                        read,
   output logic [WIDTH-1:0]            readdata,
   output logic                        readvalid,
   input  logic [ELEMENTS_W-1:0]       writeaddress,
   input  logic                        write,
   input  logic [WIDTH-1:0]            writedata,
   input  logic [(WIDTH/GRAN)-1:0]     writemask,
   output logic                        busy
);

   localparam int ELEMENTS = 2 ** ELEMENTS_W;
   localparam int LANES    = WIDTH / GRAN;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  state;
   logic [ELEMENTS_W-1:0]   clr_cnt;
   logic                    clr_last;
   logic                    clr_we;

   logic [WIDTH-1:0]        mem [ELEMENTS];

   logic                    wr_en;
   logic                    rd_acc;
   logic [WIDTH-1:0]        wr_merged;
   logic [WIDTH-1:0]        rd_word;
   logic                    fin_valid;
   logic [WIDTH-1:0]        fin_data;

   assign clr_last = (clr_cnt == ELEMENTS_W'(ELEMENTS - 1));
   assign clr_we   = !rst && (state == ST_CLEAR);
   assign wr_en    = write && !busy && !rst && (|writemask);
   assign rd_acc   = read && !busy && !rst;

   // Counter halts on the last entry; leaving ST_CLEAR is what ends the sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_cnt <= '0;
         if (CLEAR_ON_RESET != 0) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
         end else begin
            state <= ST_READY;
            busy  <= 1'b0;
         end
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_last) begin
                  state <= ST_READY;
                  busy  <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt + ELEMENTS_W'(1);
               end
            end
            ST_READY: begin
               busy <= 1'b0;
            end
            default: begin
               state <= ST_READY;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Old word with the masked lanes replaced; shared by the store and the bypass path.
   always_comb begin
      wr_merged = mem[writeaddress];
      for (int i = 0; i < LANES; i++) begin
         if (writemask[i]) begin
            wr_merged[i*GRAN +: GRAN] = writedata[i*GRAN +: GRAN];
         end
      end
   end

   always_comb begin
      rd_word = mem[readaddress];
      if ((BYPASS != 0) && wr_en && (writeaddress == readaddress)) begin
         rd_word = wr_merged;
      end
   end

   // Storage is never reset so that CLEAR_ON_RESET=0 keeps contents across rst.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_cnt] <= '0;
      end else if (wr_en) begin
         mem[writeaddress] <= wr_merged;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic             p_valid;
         logic [WIDTH-1:0] p_data;

         always_ff @(posedge clk) begin
            if (rst) begin
               p_valid <= 1'b0;
               p_data  <= '0;
            end else begin
               p_valid <= rd_acc;
               if (rd_acc) begin
                  p_data <= rd_word;
               end
            end
         end

         assign fin_valid = p_valid;
         assign fin_data  = p_data;
      end else begin : g_no_out_reg
         assign fin_valid = rd_acc;
         assign fin_data  = rd_word;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         readvalid <= 1'b0;
         readdata  <= '0;
      end else begin
         readvalid <= fin_valid;
         if (fin_valid) begin
            readdata <= fin_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_1w1r_ext.sv
// Directed bench: three instances share stimulus -- A (bypass, no out reg),
// B (read-old, out reg) and C (no clear on reset).
module tb_mem_1w1r_ext;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  ra, wa;
   logic        rd, wr;
   logic [31:0] wd;
   logic [3:0]  wm;

   logic [31:0] rd_a, rd_b, rd_c;
   logic        rv_a, rv_b, rv_c;
   logic        busy_a, busy_b, busy_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_1w1r_ext #(.ELEMENTS_W(3), .WIDTH(32), .GRAN(8), .BYPASS(1), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut_a (
      .clk(clk), .rst(rst), .readaddress(ra), .read(rd), .readdata(rd_a), .readvalid(rv_a),
      .writeaddress(wa), .write(wr), .writedata(wd), .writemask(wm), .busy(busy_a));

   mem_1w1r_ext #(.ELEMENTS_W(3), .WIDTH(32), .GRAN(8), .BYPASS(0), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_b (
      .clk(clk), .rst(rst), .readaddress(ra), .read(rd), .readdata(rd_b), .readvalid(rv_b),
      .writeaddress(wa), .write(wr), .writedata(wd), .writemask(wm), .busy(busy_b));

   mem_1w1r_ext #(.ELEMENTS_W(3), .WIDTH(32), .GRAN(8), .BYPASS(1), .OUT_REG(0), .CLEAR_ON_RESET(0)) dut_c (
      .clk(clk), .rst(rst), .readaddress(ra), .read(rd), .readdata(rd_c), .readvalid(rv_c),
      .writeaddress(wa), .write(wr), .writedata(wd), .writemask(wm), .busy(busy_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rd = 1'b0;
      wr = 1'b0;
      wm = 4'b0000;
   endtask

   task automatic set_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
      wr = 1'b1;
      wa = a;
      wd = d;
      wm = m;
   endtask

   task automatic set_rd(input logic [2:0] a);
      rd = 1'b1;
      ra = a;
   endtask

   initial begin
      rst = 1'b1;
      ra = '0; wa = '0; wd = '0;
      idle();
      tick();
      rst = 1'b0;
      chk("reset_busy_a", {31'd0, busy_a}, 32'd1);
      chk("reset_busy_b", {31'd0, busy_b}, 32'd1);
      chk("reset_busy_c", {31'd0, busy_c}, 32'd0);
      chk("reset_rv_a",   {31'd0, rv_a},   32'd0);
      chk("reset_rd_a",   rd_a, 32'h0);
      chk("reset_rd_b",   rd_b, 32'h0);
      chk("reset_rd_c",   rd_c, 32'h0);

      // Write and read during the clear sweep must be ignored
      set_wr(3'd1, 32'hFFFF_FFFF, 4'b1111);
      set_rd(3'd1);
      for (int i = 0; i < 8; i++) begin
         chk("clear_busy_a", {31'd0, busy_a}, 32'd1);
         tick();
         chk("clear_rv_a", {31'd0, rv_a}, 32'd0);
         chk("clear_rv_b", {31'd0, rv_b}, 32'd0);
      end
      idle();
      chk("ready_busy_a", {31'd0, busy_a}, 32'd0);
      chk("ready_busy_b", {31'd0, busy_b}, 32'd0);

      for (int i = 0; i < 8; i++) begin
         set_rd(3'(i));
         tick();
         chk("clr_rv_a", {31'd0, rv_a}, 32'd1);
         chk("clr_rd_a", rd_a, 32'h0);
         chk("clr_rv_b", {31'd0, rv_b}, (i > 0) ? 32'd1 : 32'd0);
         chk("clr_rd_b", rd_b, 32'h0);
         if (i == 1) chk("noclr_rd_c", rd_c, 32'hFFFF_FFFF);
      end
      idle();
      tick();
      chk("clr_tail_rv_a", {31'd0, rv_a}, 32'd0);
      chk("clr_tail_rv_b", {31'd0, rv_b}, 32'd1);
      chk("clr_tail_rd_b", rd_b, 32'h0);
      tick();
      chk("clr_tail2_rv_b", {31'd0, rv_b}, 32'd0);

      // Lane masking
      set_wr(3'd2, 32'hAABB_CCDD, 4'b1111);
      tick();
      set_wr(3'd2, 32'h1122_3344, 4'b0101);
      tick();
      idle();
      set_rd(3'd2);
      tick();
      chk("mask_rv_a", {31'd0, rv_a}, 32'd1);
      chk("mask_rd_a", rd_a, 32'hAA22_CC44);
      idle();
      tick();
      chk("hold_rv_a", {31'd0, rv_a}, 32'd0);
      chk("hold_rd_a", rd_a, 32'hAA22_CC44);
      chk("mask_rv_b", {31'd0, rv_b}, 32'd1);
      chk("mask_rd_b", rd_b, 32'hAA22_CC44);

      // Zero mask is a no-op, also on the bypass path
      set_wr(3'd2, 32'hFFFF_FFFF, 4'b0000);
      set_rd(3'd2);
      tick();
      chk("mask0_byp_a", rd_a, 32'hAA22_CC44);
      idle();
      set_rd(3'd2);
      tick();
      chk("mask0_rd_a", rd_a, 32'hAA22_CC44);
      chk("mask0_rd_b", rd_b, 32'hAA22_CC44);
      idle();
      tick();

      // Same-edge read/write, full mask
      set_wr(3'd5, 32'hDEAD_BEEF, 4'b1111);
      set_rd(3'd5);
      tick();
      chk("same_byp_a", rd_a, 32'hDEAD_BEEF);
      idle();
      tick();
      chk("same_old_rv_b", {31'd0, rv_b}, 32'd1);
      chk("same_old_rd_b", rd_b, 32'h0);
      set_rd(3'd5);
      tick();
      chk("same_after_a", rd_a, 32'hDEAD_BEEF);
      idle();
      tick();
      chk("same_after_b", rd_b, 32'hDEAD_BEEF);

      // Same-edge read/write, partial mask merge
      set_wr(3'd2, 32'h5566_7788, 4'b1000);
      set_rd(3'd2);
      tick();
      chk("merge_byp_a", rd_a, 32'h5522_CC44);
      idle();
      tick();
      chk("merge_old_b", rd_b, 32'hAA22_CC44);

      // Different addresses on the same edge
      set_wr(3'd6, 32'h0102_0304, 4'b1111);
      set_rd(3'd2);
      tick();
      chk("diff_rd_a", rd_a, 32'h5522_CC44);
      idle();
      set_rd(3'd6);
      tick();
      chk("diff_rd6_a", rd_a, 32'h0102_0304);
      chk("diff_rd_b", rd_b, 32'h5522_CC44);
      idle();
      tick();
      chk("diff_rd6_b", rd_b, 32'h0102_0304);

      // Output register latency and hold
      set_wr(3'd3, 32'h1234_5678, 4'b1111);
      tick();
      idle();
      set_rd(3'd3);
      tick();
      chk("oreg_n_rv_b", {31'd0, rv_b}, 32'd0);
      chk("oreg_n_rd_b", rd_b, 32'h0102_0304);
      idle();
      tick();
      chk("oreg_n1_rv_b", {31'd0, rv_b}, 32'd1);
      chk("oreg_n1_rd_b", rd_b, 32'h1234_5678);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("oreg_idle_rv_b", {31'd0, rv_b}, 32'd0);
         chk("oreg_idle_rd_b", rd_b, 32'h1234_5678);
      end

      // Reset in the middle of a clear sweep
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("mid_busy_a", {31'd0, busy_a}, 32'd1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_rd_a", rd_a, 32'h0);
      chk("rst2_rd_b", rd_b, 32'h0);
      chk("rst2_rd_c", rd_c, 32'h0);
      chk("rst2_busy_c", {31'd0, busy_c}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("restart_busy_a", {31'd0, busy_a}, 32'd1);
         tick();
      end
      chk("restart_done_a", {31'd0, busy_a}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         set_rd(3'(i));
         tick();
         chk("restart_rd_a", rd_a, 32'h0);
         if (i == 1) chk("keep1_rd_c", rd_c, 32'hFFFF_FFFF);
         if (i == 3) chk("keep3_rd_c", rd_c, 32'h1234_5678);
      end
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
